// File: rtl/task_responder_pkg.sv
// task_responder shared types and defaults.
// State encoding and width/timeout defaults for the pattern-stream executor.
package task_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_LEN_W   = 16;
  localparam int unsigned DEF_TO_W    = 12;
  localparam int unsigned DEF_TIMEOUT = 4000;

endpackage

// File: rtl/task_responder_stall_timer.sv
// stall_timer: saturating stall counter with clear, enable and threshold hit.
// hit_o fires on an enabled cycle whose count already equals THRESH-1.
module stall_timer
  import task_responder_pkg::*;
#(
  parameter int unsigned TO_W   = DEF_TO_W,
  parameter int unsigned THRESH = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [TO_W-1:0] LIMIT =
    TO_W'((THRESH == 0) ? 0 : THRESH - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // THRESH of zero disables the hit entirely.
  assign hit_o = (THRESH != 0) && en_i && !clr_i
               && (cnt_q == LIMIT);

endmodule

// File: rtl/task_responder.sv
// task_responder: destination-side executor for the task/ack handshake.
// Streams cmd_len incrementing words from cmd_seed, then pulses task_done.
module task_responder
  import task_responder_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned TO_W    = DEF_TO_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              task_start,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_seed,
  output logic              task_done,
  output logic              task_active,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_timeout,
  output logic [LEN_W-1:0]  beats_sent
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic              err_q, err_d;

  logic xfer;
  logic stalled;
  logic accept;
  logic to_hit;

  assign xfer    = valid_q && out_ready;
  assign stalled = valid_q && !out_ready;
  assign accept  = (state_q == ST_IDLE) && task_start;

  stall_timer #(
    .TO_W   (TO_W),
    .THRESH (TIMEOUT)
  ) u_stall (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (xfer || accept),
    .en_i  (stalled),
    .hit_o (to_hit)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    beats_d = beats_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (task_start) begin
          rem_d   = cmd_len;
          data_d  = cmd_seed;
          beats_d = '0;
          err_d   = 1'b0;
          if (cmd_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            valid_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // A transfer always beats a coincident timeout.
        if (xfer) begin
          data_d  = data_q + DATA_W'(1);
          beats_d = beats_q + LEN_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end
        end else if (to_hit) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      beats_q <= beats_d;
      err_q   <= err_d;
    end
  end

  assign task_done   = (state_q == ST_DONE);
  assign task_active = (state_q != ST_IDLE);
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign err_timeout = err_q;
  assign beats_sent  = beats_q;

  a_start_idle : assert property (
    @(posedge clk) disable iff (!rstn)
    task_start |-> (state_q == ST_IDLE)
  );

endmodule

// File: doc/task_responder.md
Name: task_responder

Overview:
- Destination-side executor for the task/acknowledge clock-crossing handshake. It runs in the destination clock domain only.
- Consumes the single-cycle task-start pulse produced by the crossing. It then emits a programmed number of pattern words over a valid/ready stream, used for trace-link training and flush.
- When the task finishes, it returns a single-cycle task-done pulse that the crossing carries back to the requesting domain.
- An optional stall timeout aborts a task whose sink stops accepting data.

Parameters:
- DATA_W, 32, width of output pattern word.
- LEN_W, 16, width of word-count command.
- TO_W, 12, width of stall-timeout counter.
- TIMEOUT, 4000, consecutive stalled cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- task_start  in  1  one-cycle start pulse from the crossing.
- cmd_len  in  LEN_W  number of words to emit; sampled on task_start.
- cmd_seed  in  DATA_W  first pattern word; sampled on task_start.
- task_done  out  1  one-cycle completion pulse, fed to the crossing's done input.
- task_active  out  1  high from the cycle after task_start until the cycle task_done is high, inclusive.
- out_data  out  DATA_W  pattern word.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- err_timeout  out  1  sticky abort flag; cleared on the next accepted task_start.
- beats_sent  out  LEN_W  beats accepted in the current or last task.

Behaviour:
- Reset: while rstn is low, all outputs are 0 and state is IDLE. Reset takes effect asynchronously; release is synchronous to clk. Reset mid-task drops out_valid immediately and produces no task_done.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, task_start=1:
  - Latch cmd_len into the remaining counter and cmd_seed into out_data.
  - Clear beats_sent, err_timeout and the stall counter.
  - If cmd_len=0, go to DONE. Otherwise go to RUN with out_valid=1 on the next cycle.
- task_start outside IDLE is ignored. The crossing guarantees it cannot occur, and an assertion flags it.
- RUN, transfer rules:
  - A beat transfers when out_valid and out_ready are both 1.
  - On each beat: out_data increments by 1 (mod 2^DATA_W), beats_sent increments, remaining decrements.
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- RUN, last beat (remaining=1 at transfer): out_valid=0 next cycle, and the state goes to DONE.
- RUN, stall timeout:
  - The stall counter increments on every cycle with out_valid=1 and out_ready=0, and clears on any transfer.
  - If TIMEOUT is nonzero and the counter reaches TIMEOUT-1 while still stalled, the task aborts.
  - Abort means: out_valid=0 next cycle, err_timeout=1, state goes to DONE. The beat being offered is not counted.
  - If a transfer and the timeout threshold occur in the same cycle, the transfer wins and the counter clears.
- DONE: task_done=1 for exactly one cycle, then IDLE. The next task_start is accepted in the cycle after DONE at the earliest.
- Latency:
  - task_start at cycle t gives the first out_valid at t+1.
  - An N-beat task with ready held at 1 has its last transfer at t+N and task_done at t+N+1.
  - For cmd_len=0, task_done is at t+1.
- beats_sent holds its value after the task until the next task_start. It wraps at 2^LEN_W, which is unreachable because the count is bounded by cmd_len.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/RUN/DONE, 2-bit encoding);
  - default widths DATA_W/LEN_W/TO_W;
  - the TIMEOUT default.
- One natural sub-module: stall_timer. It is the saturating stall counter with clear, enable and a threshold-hit output, reused by other stream engines.
- The crossing itself is instantiated by the parent. It is not part of this block.

Test Plan:
- Reset then start with len=4, seed=0x10, ready=1 -> data 0x10,0x11,0x12,0x13 on consecutive cycles t+1..t+4; task_done at t+5 only; beats_sent=4; err_timeout=0.
- len=0 start -> no out_valid; task_done at t+1; beats_sent=0.
- len=3, ready toggling 1,0,0,1,1 -> data stable during stalls; exactly 3 transfers; task_done one cycle after the third transfer.
- TIMEOUT=8, len=5, ready=1 for 2 beats then 0 -> abort after 8 stalled cycles; err_timeout=1; beats_sent=2; single task_done. A following task_start clears err_timeout.
- Seed=0xFFFFFFFF, len=2 -> data 0xFFFFFFFF then 0x00000000.
- rstn low mid-RUN -> out_valid, task_active and task_done at 0 asynchronously. After release, a fresh start behaves as in the first scenario.
